// File: rtl/sfp_accum_unit.sv
// rtl/sfp_accum_unit.sv - multi-lane psum accumulator bank with relu, saturation and row drain
module sfp_accum_unit #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int acc_bw  = 20,
  parameter int lanes   = 2,
  parameter int depth   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [7:0]               num_tiles,
  input  logic [$clog2(depth):0]   num_rows,
  input  logic                     relu_en,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic [col*psum_bw-1:0]   in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [col*psum_bw-1:0]   out_data,
  output logic                     busy,
  output logic                     done
);

  localparam int RW  = $clog2(depth) + 1;
  localparam int AW  = (depth > 1) ? $clog2(depth) : 1;
  localparam int NCH = col / lanes;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CIW = (col > 1) ? $clog2(col) : 1;

  localparam logic signed [acc_bw:0]   ACC_MAX_X = {2'b00, {(acc_bw-1){1'b1}}};
  localparam logic signed [acc_bw:0]   ACC_MIN_X = {2'b11, {(acc_bw-1){1'b0}}};
  localparam logic signed [acc_bw-1:0] OUT_MAX   = {{(acc_bw-psum_bw+1){1'b0}}, {(psum_bw-1){1'b1}}};
  localparam logic signed [acc_bw-1:0] OUT_MIN   = {{(acc_bw-psum_bw+1){1'b1}}, {(psum_bw-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE1} state_t;

  // One extra bit of headroom is enough to detect overflow of a single add.
  function automatic logic signed [acc_bw-1:0] sat_acc(input logic signed [acc_bw:0] s);
    if (s > ACC_MAX_X)      return ACC_MAX_X[acc_bw-1:0];
    else if (s < ACC_MIN_X) return ACC_MIN_X[acc_bw-1:0];
    else                    return s[acc_bw-1:0];
  endfunction

  function automatic logic [psum_bw-1:0] drain_val(input logic signed [acc_bw-1:0] a,
                                                   input logic relu);
    logic signed [acc_bw-1:0] x;
    x = (relu && (a < 0)) ? '0 : a;
    if (x > OUT_MAX)      x = OUT_MAX;
    else if (x < OUT_MIN) x = OUT_MIN;
    return x[psum_bw-1:0];
  endfunction

  state_t                  state_q, state_d;
  logic [7:0]              tiles_q, tiles_d, tile_cnt_q, tile_cnt_d;
  logic [RW-1:0]           rows_q, rows_d, row_cnt_q, row_cnt_d, rd_ptr_q, rd_ptr_d;
  logic                    relu_q, relu_d, hold_q, hold_d;
  logic [CW-1:0]           chunk_q, chunk_d;
  logic [col*psum_bw-1:0]  vec_q, vec_d, out_data_q, out_data_d, drain_row;
  logic                    out_valid_q, out_valid_d, done_q, done_d;

  logic signed [acc_bw-1:0]  acc_bank [depth][col];
  logic signed [acc_bw-1:0]  acc_wr   [lanes];
  logic signed [acc_bw-1:0]  lane_old [lanes];
  logic signed [psum_bw-1:0] lane_psum[lanes];
  logic [CIW-1:0]            cidx     [lanes];

  logic [RW-1:0] rows_eff;
  logic [AW-1:0] row_idx, rd_idx;
  logic          accept, bank_we;

  assign rows_eff  = (num_rows > RW'(depth)) ? RW'(depth) : num_rows;
  assign row_idx   = row_cnt_q[AW-1:0];
  assign rd_idx    = rd_ptr_q[AW-1:0];
  assign in_ready  = (state_q == ACCUM) && !hold_q && !clear;
  assign accept    = in_valid && in_ready;
  assign bank_we   = (state_q == ACCUM) && hold_q && !clear;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign done      = done_q;

  // New accumulator values for the lanes of the current chunk.
  always_comb begin
    for (int l = 0; l < lanes; l++) begin
      cidx[l]      = CIW'(int'(chunk_q) * lanes + l);
      lane_psum[l] = vec_q[int'(cidx[l]) * psum_bw +: psum_bw];
      lane_old[l]  = acc_bank[row_idx][cidx[l]];
      if (tile_cnt_q == 8'd0) acc_wr[l] = acc_bw'(lane_psum[l]);
      else acc_wr[l] = sat_acc((acc_bw+1)'(lane_old[l]) + (acc_bw+1)'(lane_psum[l]));
    end
  end

  // Relu and output clamp of the row currently selected for draining.
  always_comb begin
    drain_row = '0;
    for (int c = 0; c < col; c++) begin
      drain_row[c*psum_bw +: psum_bw] = drain_val(acc_bank[rd_idx][c], relu_q);
    end
  end

  // Accumulator bank write; deliberately unreset since tile 0 overwrites.
  always_ff @(posedge clk) begin
    if (bank_we) begin
      for (int l = 0; l < lanes; l++) acc_bank[row_idx][cidx[l]] <= acc_wr[l];
    end
  end

  // Job sequencing: accept vectors, walk chunks/rows/tiles, then drain rows.
  always_comb begin
    state_d     = state_q;
    tiles_d     = tiles_q;
    rows_d      = rows_q;
    relu_d      = relu_q;
    tile_cnt_d  = tile_cnt_q;
    row_cnt_d   = row_cnt_q;
    rd_ptr_d    = rd_ptr_q;
    hold_d      = hold_q;
    chunk_d     = chunk_q;
    vec_d       = vec_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    if (clear) begin
      state_d     = IDLE;
      tile_cnt_d  = '0;
      row_cnt_d   = '0;
      rd_ptr_d    = '0;
      hold_d      = 1'b0;
      chunk_d     = '0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            tiles_d    = num_tiles;
            rows_d     = rows_eff;
            relu_d     = relu_en;
            tile_cnt_d = '0;
            row_cnt_d  = '0;
            rd_ptr_d   = '0;
            hold_d     = 1'b0;
            chunk_d    = '0;
            if ((num_tiles == 8'd0) || (rows_eff == '0)) begin
              state_d = DONE1;
              done_d  = 1'b1;
            end else begin
              state_d = ACCUM;
            end
          end
        end
        ACCUM: begin
          if (hold_q) begin
            chunk_d = chunk_q + CW'(1);
            if (chunk_q == CW'(NCH - 1)) begin
              hold_d  = 1'b0;
              chunk_d = '0;
              if (row_cnt_q == rows_q - RW'(1)) begin
                row_cnt_d  = '0;
                tile_cnt_d = tile_cnt_q + 8'd1;
                if (tile_cnt_q == tiles_q - 8'd1) begin
                  state_d  = DRAIN;
                  rd_ptr_d = '0;
                end
              end else begin
                row_cnt_d = row_cnt_q + RW'(1);
              end
            end
          end else if (accept) begin
            vec_d   = in_data;
            hold_d  = 1'b1;
            chunk_d = '0;
          end
        end
        DRAIN: begin
          if (!out_valid_q || out_ready) begin
            if (rd_ptr_q < rows_q) begin
              out_data_d  = drain_row;
              out_valid_d = 1'b1;
              rd_ptr_d    = rd_ptr_q + RW'(1);
            end else begin
              out_valid_d = 1'b0;
              if (out_valid_q) begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      tiles_q     <= '0;
      rows_q      <= '0;
      relu_q      <= 1'b0;
      tile_cnt_q  <= '0;
      row_cnt_q   <= '0;
      rd_ptr_q    <= '0;
      hold_q      <= 1'b0;
      chunk_q     <= '0;
      vec_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tiles_q     <= tiles_d;
      rows_q      <= rows_d;
      relu_q      <= relu_d;
      tile_cnt_q  <= tile_cnt_d;
      row_cnt_q   <= row_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      hold_q      <= hold_d;
      chunk_q     <= chunk_d;
      vec_q       <= vec_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_sfp_accum_unit.sv
// tb/tb_sfp_accum_unit.sv - self-checking bench for sfp_accum_unit
module tb_sfp_accum_unit;
  localparam int COL = 8, PBW = 16, ABW = 20, LANES = 2, DEPTH = 16, RW = 5;
  localparam int W = COL * PBW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0, relu_en = 1'b0, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [7:0]    num_tiles = '0;
  logic [RW-1:0] num_rows = '0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready, out_valid, busy, done;
  logic [W-1:0]  out_data;

  always #5 clk = ~clk;

  sfp_accum_unit #(.col(COL), .psum_bw(PBW), .acc_bw(ABW), .lanes(LANES), .depth(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .num_tiles(num_tiles), .num_rows(num_rows),
    .relu_en(relu_en), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );

  int checks = 0, failures = 0, done_cnt = 0, rows_seen = 0;
  int vm [0:39][0:15][0:COL-1];
  logic [W-1:0] exp_q[$];
  logic bp_en = 1'b0, ready_lvl = 1'b1;
  logic [3:0] bp_pat = 4'b1001;
  int bp_idx = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic chk_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic longint clampv(input longint v, input int bw);
    longint hi, lo;
    hi = (longint'(1) <<< (bw - 1)) - 1;
    lo = -(longint'(1) <<< (bw - 1));
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  // Reference: running saturating sum over tiles, then relu and output clamp.
  function automatic longint model(input int tiles, input int r, input int c, input bit relu);
    longint acc = 0;
    for (int t = 0; t < tiles; t++) acc = clampv(acc + longint'(vm[t][r][c]), ABW);
    if (relu && acc < 0) acc = 0;
    return clampv(acc, PBW);
  endfunction

  function automatic logic [W-1:0] model_row(input int tiles, input int r, input bit relu);
    logic [W-1:0] v;
    for (int c = 0; c < COL; c++) v[c*PBW +: PBW] = PBW'(model(tiles, r, c, relu));
    return v;
  endfunction

  function automatic logic [W-1:0] pack_vec(input int t, input int r);
    logic [W-1:0] v;
    for (int c = 0; c < COL; c++) v[c*PBW +: PBW] = PBW'(vm[t][r][c]);
    return v;
  endfunction

  function automatic int eff_rows(input int rows);
    return (rows > DEPTH) ? DEPTH : rows;
  endfunction

  // Downstream ready: steady level or the repeating 1,0,0,1 backpressure pattern.
  initial forever begin
    @(posedge clk); #1;
    if (bp_en) begin
      out_ready = bp_pat[bp_idx];
      bp_idx = (bp_idx + 1) % 4;
    end else begin
      out_ready = ready_lvl;
    end
  end

  // Compare process: every handed-off row against the model queue, stall stability, done pulses.
  initial begin : compare
    logic [W-1:0] sd;
    bit sp;
    sp = 0;
    sd = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        sp = 0;
      end else begin
        if (sp && out_valid) chk_vec("stall_hold", out_data, sd);
        if (out_valid && out_ready) begin
          rows_seen++;
          if (exp_q.size() == 0) chk("row_expected", 0, 1);
          else chk_vec("row", out_data, exp_q.pop_front());
        end
        sp = out_valid && !out_ready;
        sd = out_data;
        if (done) done_cnt++;
      end
    end
  end

  task automatic start_job(input int tiles, input int rows, input bit relu, input bit expect_out);
    if (expect_out && tiles > 0)
      for (int r = 0; r < eff_rows(rows); r++) exp_q.push_back(model_row(tiles, r, relu));
    num_tiles = 8'(tiles);
    num_rows  = RW'(rows);
    relu_en   = relu;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic send_one(input int t, input int r);
    bit fired;
    int n;
    in_data  = pack_vec(t, r);
    in_valid = 1'b1;
    n = 0;
    fired = 0;
    while (!fired && n < 200) begin
      @(negedge clk);
      fired = in_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!fired) chk("in_accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_all(input int tiles, input int rows, input bit gap);
    for (int t = 0; t < tiles; t++)
      for (int r = 0; r < eff_rows(rows); r++) begin
        send_one(t, r);
        if (gap) begin @(posedge clk); #1; end
      end
  endtask

  task automatic wait_done(input string name, input int d0, input int r0, input int nrows);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 2000) begin @(posedge clk); n++; end
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_done_count"}, done_cnt - d0, 1);
    chk({name, "_rows"}, rows_seen - r0, nrows);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin : main
    int d0, r0, n;
    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk_vec("rst_out_data", out_data, '0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // 1: single tile, two rows, constant vectors.
    for (int c = 0; c < COL; c++) begin vm[0][0][c] = 5; vm[0][1][c] = -3; end
    chk_vec("pin_t1_row0", model_row(1, 0, 0), {8{16'h0005}});
    chk_vec("pin_t1_row1", model_row(1, 1, 0), {8{16'hfffd}});
    d0 = done_cnt; r0 = rows_seen;
    start_job(1, 2, 0, 1);
    send_all(1, 2, 0);
    wait_done("t1", d0, r0, 2);

    // 2: three tiles with relu, per-column values and a negative row.
    for (int t = 0; t < 3; t++)
      for (int c = 0; c < COL; c++) begin vm[t][0][c] = c + 1; vm[t][1][c] = -4; end
    chk("pin_t2_c7", model(3, 0, 7, 1), 24);
    chk("pin_t2_neg", model(3, 1, 0, 1), 0);
    d0 = done_cnt; r0 = rows_seen;
    start_job(3, 2, 1, 1);
    send_all(3, 2, 0);
    wait_done("t2", d0, r0, 2);

    // 3: saturation of the output clamp and of the accumulator itself.
    for (int t = 0; t < 4; t++) for (int c = 0; c < COL; c++) vm[t][0][c] = 32767;
    chk("pin_sat_pos", model(4, 0, 0, 0), 32767);
    d0 = done_cnt; r0 = rows_seen;
    start_job(4, 1, 0, 1);
    send_all(4, 1, 0);
    wait_done("t3a", d0, r0, 1);
    for (int t = 0; t < 33; t++)
      for (int c = 0; c < COL; c++) begin
        vm[t][0][c] = (t < 17) ? 32767 : -32768;
        vm[t][1][c] = -32768;
      end
    chk("pin_sat_recover", model(33, 0, 0, 0), -1);
    chk("pin_sat_neg", model(33, 1, 0, 0), -32768);
    d0 = done_cnt; r0 = rows_seen;
    start_job(33, 2, 0, 1);
    send_all(33, 2, 0);
    wait_done("t3b", d0, r0, 2);

    // 4: downstream backpressure.
    for (int t = 0; t < 2; t++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < COL; c++) vm[t][r][c] = (r * 10 + c) * (t + 1);
    chk("pin_bp", model(2, 3, 5, 0), 105);
    bp_en = 1'b1;
    d0 = done_cnt; r0 = rows_seen;
    start_job(2, 4, 0, 1);
    send_all(2, 4, 0);
    wait_done("t4", d0, r0, 4);
    bp_en = 1'b0;

    // 5: input gaps with an ignored start mid-job, empty jobs, oversized row count.
    for (int t = 0; t < 2; t++)
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < COL; c++) vm[t][r][c] = (t + 1) * (c - 2 * r);
    d0 = done_cnt; r0 = rows_seen;
    start_job(2, 3, 0, 1);
    num_tiles = 8'd5; num_rows = RW'(1); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    send_all(2, 3, 1);
    wait_done("t5_gap", d0, r0, 3);
    d0 = done_cnt; r0 = rows_seen;
    start_job(0, 3, 0, 1);
    wait_done("t5_zero_tiles", d0, r0, 0);
    d0 = done_cnt; r0 = rows_seen;
    start_job(2, 0, 0, 1);
    wait_done("t5_zero_rows", d0, r0, 0);
    for (int r = 0; r < 16; r++) for (int c = 0; c < COL; c++) vm[0][r][c] = r * 100 - c;
    d0 = done_cnt; r0 = rows_seen;
    start_job(1, 17, 0, 1);
    send_all(1, 17, 0);
    wait_done("t5_rows_over_depth", d0, r0, 16);

    // 6a: clear mid-accumulation, with a vector offered on the clear cycle.
    for (int c = 0; c < COL; c++) begin vm[0][0][c] = 7; vm[0][1][c] = 7; end
    d0 = done_cnt;
    start_job(2, 2, 0, 0);
    send_one(0, 0);
    clear = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    chk("clear_in_ready", in_ready, 0);
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("clear_busy", busy, 0);
    chk("clear_in_ready_after", in_ready, 0);
    chk("clear_out_valid", out_valid, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("clear_no_done", done_cnt - d0, 0);
    for (int c = 0; c < COL; c++) begin vm[0][0][c] = 9 * c; vm[0][1][c] = -9; end
    d0 = done_cnt; r0 = rows_seen;
    start_job(1, 2, 0, 1);
    send_all(1, 2, 0);
    wait_done("t6_after_clear", d0, r0, 2);

    // 6b: reset while holding a finished row in drain.
    ready_lvl = 1'b0;
    @(posedge clk); #1;
    for (int r = 0; r < 3; r++) for (int c = 0; c < COL; c++) vm[0][r][c] = 11 + r;
    start_job(1, 3, 0, 0);
    send_all(1, 3, 0);
    n = 0;
    while (!out_valid && n < 300) begin @(negedge clk); n++; end
    chk("drain_reached", out_valid, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk_vec("rst_mid_out_data", out_data, '0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    ready_lvl = 1'b1;
    @(posedge clk); #1;
    for (int t = 0; t < 2; t++)
      for (int r = 0; r < 2; r++) for (int c = 0; c < COL; c++) vm[t][r][c] = 1000 * r - 300 * c + t;
    d0 = done_cnt; r0 = rows_seen;
    start_job(2, 2, 1, 1);
    send_all(2, 2, 0);
    wait_done("t6_after_reset", d0, r0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
